// File: rtl/axi_block_pkg.sv
// Shared types and constants for the AXI cache-block adapter.
// State encoding, beat count, AXI size/burst encodings and response codes.
package axi_block_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        DONE
    } state_e;

    localparam int BEATS = 16;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int beats_of(input int block_w, input int word_w);
        return block_w / word_w;
    endfunction

endpackage

// File: rtl/block_beat_shifter.sv
// Beat counter plus block<->word datapath for one cache-block burst.
// Ports: i_clk, i_arst, i_clr (hold counter at 0), i_load/i_load_block
// (capture writeback block), i_wr_beat (shift out one word), i_rd_beat/
// i_rd_word (store one word), o_wr_word, o_rd_block, o_cnt, o_last.
module block_beat_shifter
    import axi_block_pkg::*;
#(
    parameter int WORD_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 512,
    parameter int CNT_W       = $clog2(BLOCK_WIDTH / WORD_WIDTH)
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_clr,
    input  logic                   i_load,
    input  logic [BLOCK_WIDTH-1:0] i_load_block,
    input  logic                   i_wr_beat,
    input  logic                   i_rd_beat,
    input  logic [WORD_WIDTH-1:0]  i_rd_word,
    output logic [WORD_WIDTH-1:0]  o_wr_word,
    output logic [BLOCK_WIDTH-1:0] o_rd_block,
    output logic [CNT_W-1:0]       o_cnt,
    output logic                   o_last
);

    localparam int NB = beats_of(BLOCK_WIDTH, WORD_WIDTH);

    logic [BLOCK_WIDTH-1:0] wblk;

    assign o_last    = (o_cnt == CNT_W'(NB - 1));
    assign o_wr_word = wblk[WORD_WIDTH-1:0];

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_cnt <= '0;
        end else if (i_clr) begin
            o_cnt <= '0;
        end else if (i_rd_beat || i_wr_beat) begin
            // natural wrap only happens on the final beat of a burst
            o_cnt <= o_last ? '0 : o_cnt + CNT_W'(1);
        end
    end

    // Writeback words leave LSB first, so shift the block down each beat.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            wblk <= '0;
        end else if (i_load) begin
            wblk <= i_load_block;
        end else if (i_wr_beat) begin
            wblk <= wblk >> WORD_WIDTH;
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_rd_block <= '0;
        end else if (i_rd_beat) begin
            for (int i = 0; i < NB; i++) begin
                if (o_cnt == CNT_W'(i)) begin
                    o_rd_block[i*WORD_WIDTH +: WORD_WIDTH] <= i_rd_word;
                end
            end
        end
    end

endmodule

// File: rtl/axi_block_adapter.sv
// Converts core block refill/writeback requests into single AXI INCR bursts.
// Ports: core side (i_axi_read_start, i_axi_write_start, i_axi_addr,
// i_data_block, o_axi_done, o_data_block, o_axi_err), AXI AR/R/AW/W/B.
// AXI_RESP_CHECK_EN enables the sticky o_axi_err response/rlast checker.
module axi_block_adapter
    import axi_block_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int WORD_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 512
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_axi_read_start,
    input  logic                   i_axi_write_start,
    input  logic [ADDR_WIDTH-1:0]  i_axi_addr,
    input  logic [BLOCK_WIDTH-1:0] i_data_block,
    output logic                   o_axi_done,
    output logic [BLOCK_WIDTH-1:0] o_data_block,
    output logic                   o_axi_err,
    output logic [ADDR_WIDTH-1:0]  o_araddr,
    output logic [7:0]             o_arlen,
    output logic [2:0]             o_arsize,
    output logic [1:0]             o_arburst,
    output logic                   o_arvalid,
    input  logic                   i_arready,
    input  logic [WORD_WIDTH-1:0]  i_rdata,
    input  logic [1:0]             i_rresp,
    input  logic                   i_rlast,
    input  logic                   i_rvalid,
    output logic                   o_rready,
    output logic [ADDR_WIDTH-1:0]  o_awaddr,
    output logic [7:0]             o_awlen,
    output logic [2:0]             o_awsize,
    output logic [1:0]             o_awburst,
    output logic                   o_awvalid,
    input  logic                   i_awready,
    output logic [WORD_WIDTH-1:0]  o_wdata,
    output logic [3:0]             o_wstrb,
    output logic                   o_wlast,
    output logic                   o_wvalid,
    input  logic                   i_wready,
    input  logic [1:0]             i_bresp,
    input  logic                   i_bvalid,
    output logic                   o_bready
);

    localparam int NB    = beats_of(BLOCK_WIDTH, WORD_WIDTH);
    localparam int CNT_W = $clog2(NB);
    localparam int OFF   = $clog2(BLOCK_WIDTH / 8);

    localparam logic [ADDR_WIDTH-1:0] BLK_MASK =
        {{(ADDR_WIDTH-OFF){1'b1}}, {OFF{1'b0}}};

    state_e                  state;
    state_e                  state_n;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    take_rd;
    logic                    take_wr;
    logic                    rd_beat;
    logic                    wr_beat;
    logic                    last;
    logic [CNT_W-1:0]        cnt;
    logic [WORD_WIDTH-1:0]   wr_word;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        take_rd = 1'b0;
        take_wr = 1'b0;
        rd_beat = 1'b0;
        wr_beat = 1'b0;
        unique case (state)
            IDLE: begin
                // writeback wins so a dirty victim leaves before the refill
                if (i_axi_write_start) begin
                    take_wr = 1'b1;
                    state_n = WR_ADDR;
                end else if (i_axi_read_start) begin
                    take_rd = 1'b1;
                    state_n = RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (i_arready) state_n = RD_DATA;
            end
            RD_DATA: begin
                if (i_rvalid) begin
                    rd_beat = 1'b1;
                    if (last) state_n = DONE;
                end
            end
            WR_ADDR: begin
                if (i_awready) state_n = WR_DATA;
            end
            WR_DATA: begin
                if (i_wready) begin
                    wr_beat = 1'b1;
                    if (last) state_n = WR_RESP;
                end
            end
            WR_RESP: begin
                if (i_bvalid) state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            addr_q <= '0;
        end else if (take_rd || take_wr) begin
            addr_q <= i_axi_addr & BLK_MASK;
        end
    end

    block_beat_shifter #(
        .WORD_WIDTH  (WORD_WIDTH),
        .BLOCK_WIDTH (BLOCK_WIDTH),
        .CNT_W       (CNT_W)
    ) u_shifter (
        .i_clk        (i_clk),
        .i_arst       (i_arst),
        .i_clr        (state == IDLE),
        .i_load       (take_wr),
        .i_load_block (i_data_block),
        .i_wr_beat    (wr_beat),
        .i_rd_beat    (rd_beat),
        .i_rd_word    (i_rdata),
        .o_wr_word    (wr_word),
        .o_rd_block   (o_data_block),
        .o_cnt        (cnt),
        .o_last       (last)
    );

    assign o_araddr  = addr_q;
    assign o_arlen   = 8'(NB - 1);
    assign o_arsize  = AXI_SIZE_4B;
    assign o_arburst = AXI_BURST_INCR;
    assign o_arvalid = (state == RD_ADDR);
    assign o_rready  = (state == RD_DATA);

    assign o_awaddr  = addr_q;
    assign o_awlen   = 8'(NB - 1);
    assign o_awsize  = AXI_SIZE_4B;
    assign o_awburst = AXI_BURST_INCR;
    assign o_awvalid = (state == WR_ADDR);

    assign o_wdata   = wr_word;
    assign o_wstrb   = 4'hF;
    assign o_wvalid  = (state == WR_DATA);
    assign o_wlast   = (state == WR_DATA) && last;
    assign o_bready  = (state == WR_RESP);

    assign o_axi_done = (state == DONE);

`ifdef AXI_RESP_CHECK_EN
    logic err_q;
    logic rd_bad;
    logic wr_bad;

    // rlast must coincide exactly with the final counted beat
    assign rd_bad = rd_beat && ((i_rresp != RESP_OKAY) || (i_rlast != last));
    assign wr_bad = (state == WR_RESP) && i_bvalid && (i_bresp != RESP_OKAY);

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            err_q <= 1'b0;
        end else if (rd_bad || wr_bad) begin
            err_q <= 1'b1;
        end
    end

    assign o_axi_err = err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{i_rresp, i_rlast, i_bresp};
    assign o_axi_err   = 1'b0;
`endif

    logic unused_cnt;
    assign unused_cnt = ^cnt;

endmodule
